// File: rtl/inst_fetch_aligner.sv
// inst_fetch_aligner
// Fetch front end: issues word-aligned reads to a registered instruction
// memory, buffers the returned halfwords in a 4-entry queue and realigns them
// into 16-bit compressed or 32-bit RV32IC instructions for decode.
// A redirect flushes the queue and restarts fetch at the new PC.

// Structural invariants of the aligner, kept out of the datapath module.
module inst_fetch_aligner_chk #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  input logic [3:0] fill_sum,
  input logic [1:0] mem_addr_lsb
);

  // The issue throttle must keep the queue from ever exceeding its depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    int'(fill_sum) <= DEPTH);

  // Fetch addresses are always word aligned.
  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    mem_addr_lsb == 2'b00);

endmodule

module inst_fetch_aligner #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH_HW = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_write,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_c
);

  typedef enum logic {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [15:0] q_r       [4];
  logic [15:0] q_shift_s [4];
  logic [15:0] q_nxt_s   [4];
  logic [2:0]  count_r;
  logic        pending_r;
  logic        drop_lo_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] head_pc_r;

  logic [15:0] h0_s;
  logic [15:0] h1_s;
  logic [1:0]  pop_s;
  logic [2:0]  keep_s;
  logic [1:0]  in_cnt_s;
  logic [15:0] in_hw0_s;
  logic [15:0] in_hw1_s;
  logic [3:0]  fill_sum_s;
  logic [2:0]  count_nxt_s;

  assign mem_addr  = fetch_pc_r;
  assign mem_size  = 2'b10;
  assign mem_write = 1'b0;
  assign h0_s      = q_r[0];
  assign h1_s      = q_r[1];

  // FSM state register: FLUSH is entered on reset and on every redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FLUSH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a redirect always (re)starts the one-cycle FLUSH.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = ST_FLUSH;
    end else begin
      case (state_r)
        ST_FLUSH: state_nxt_s = ST_RUN;
        ST_RUN:   state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_FLUSH;
      endcase
    end
  end

  // FSM output: issue only when queue plus in-flight word is guaranteed to fit.
  always_comb begin
    mem_req = 1'b0;
    case (state_r)
      ST_RUN:  mem_req = (({1'b0, count_r} + (pending_r ? 4'd2 : 4'd0)) <= 4'd2);
      default: mem_req = 1'b0;
    endcase
  end

  // Instruction decode from the queue head; an empty queue presents zeros.
  always_comb begin
    inst_valid = 1'b0;
    inst_is_c  = 1'b0;
    inst_data  = 32'h0000_0000;
    inst_pc    = head_pc_r;
    if (count_r == 3'd0) begin
      inst_valid = 1'b0;
    end else if (h0_s[1:0] != 2'b11) begin
      inst_is_c  = 1'b1;
      inst_valid = 1'b1;
      inst_data  = {16'h0000, h0_s};
    end else begin
      inst_valid = (count_r >= 3'd2);
      inst_data  = {h1_s, h0_s};
    end
  end

  // Halfwords consumed by decode this cycle.
  always_comb begin
    pop_s = 2'd0;
    if (inst_valid && inst_ready) begin
      pop_s = inst_is_c ? 2'd1 : 2'd2;
    end else begin
      pop_s = 2'd0;
    end
  end

  // Halfwords arriving from memory; a misaligned target skips the low half.
  always_comb begin
    in_cnt_s = 2'd0;
    in_hw0_s = mem_rdata[15:0];
    in_hw1_s = mem_rdata[31:16];
    if (pending_r && drop_lo_r) begin
      in_cnt_s = 2'd1;
      in_hw0_s = mem_rdata[31:16];
    end else if (pending_r) begin
      in_cnt_s = 2'd2;
    end else begin
      in_cnt_s = 2'd0;
    end
  end

  assign keep_s      = count_r - {1'b0, pop_s};
  assign fill_sum_s  = {1'b0, keep_s} + {2'b00, in_cnt_s};
  assign count_nxt_s = fill_sum_s[2:0];

  // Next queue contents: shift out popped halfwords, then append at the tail.
  always_comb begin
    case (pop_s)
      2'd1: begin
        q_shift_s[0] = q_r[1];
        q_shift_s[1] = q_r[2];
        q_shift_s[2] = q_r[3];
        q_shift_s[3] = 16'h0000;
      end
      2'd2: begin
        q_shift_s[0] = q_r[2];
        q_shift_s[1] = q_r[3];
        q_shift_s[2] = 16'h0000;
        q_shift_s[3] = 16'h0000;
      end
      default: begin
        q_shift_s = q_r;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      if ((in_cnt_s != 2'd0) && (keep_s == 3'(i))) begin
        q_nxt_s[i] = in_hw0_s;
      end else if ((in_cnt_s == 2'd2) && ((keep_s + 3'd1) == 3'(i))) begin
        q_nxt_s[i] = in_hw1_s;
      end else begin
        q_nxt_s[i] = q_shift_s[i];
      end
    end
  end

  // Queue, fetch and PC tracking registers; redirect overrides all updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        q_r[i] <= 16'h0000;
      end
      count_r    <= 3'd0;
      pending_r  <= 1'b0;
      drop_lo_r  <= RESET_PC[1];
      fetch_pc_r <= RESET_PC & 32'hFFFF_FFFC;
      head_pc_r  <= RESET_PC;
    end else if (redirect_valid) begin
      count_r    <= 3'd0;
      pending_r  <= 1'b0;
      drop_lo_r  <= redirect_pc[1];
      fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      head_pc_r  <= redirect_pc & 32'hFFFF_FFFE;
    end else begin
      q_r       <= q_nxt_s;
      count_r   <= count_nxt_s;
      pending_r <= mem_req;
      if (mem_req) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (pending_r && drop_lo_r) begin
        drop_lo_r <= 1'b0;
      end
      head_pc_r <= head_pc_r + {29'd0, pop_s, 1'b0};
    end
  end

  inst_fetch_aligner_chk #(.DEPTH(QDEPTH_HW)) u_chk (
    .clk          (clk),
    .rst          (rst),
    .fill_sum     (fill_sum_s),
    .mem_addr_lsb (fetch_pc_r[1:0])
  );

endmodule
